// File: rtl/mp_serializer_hs.sv
// mp_serializer_hs: parallel word in (valid/ready), lanes_p-bit beats out (valid/ready),
//   with sof/eof marking the first and last beat of each word.
// Latency: first beat of an accepted word is valid one cycle after acceptance.
// Backpressure: ready_i low freezes data_o/sof_o/eof_o; v_o stays high until the beat transfers.
//
// Ports:
//   clk_i, reset_i    single clock, synchronous active-high reset
//   data_i, v_i       parallel word and its valid; sampled when v_i & ready_o
//   ready_o           a buffer slot is free (depends only on state, never on v_i/ready_i)
//   data_o, v_o       current serial beat and its valid
//   ready_i           downstream accepts the beat (transfer when v_o & ready_i)
//   sof_o, eof_o      beat 0 / last beat of a word, qualified by v_o
//
// Build option: define MP_SERIALIZER_PARITY_EN to append one trailing beat per word that
// carries per-lane even parity (bit k = XOR of all bits sent on lane k for that word);
// eof_o then flags the parity beat instead of the last data beat.
//
// width_p must be a multiple of lanes_p with width_p/lanes_p >= 2.

module mp_serializer_hs #(
  parameter int width_p     = 256,
  parameter int lanes_p     = 1,
  parameter int lsb_first_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [lanes_p-1:0] data_o,
  output logic               v_o,
  input  logic               ready_i,
  output logic               sof_o,
  output logic               eof_o
);

  localparam int beats_lp = width_p / lanes_p;
`ifdef MP_SERIALIZER_PARITY_EN
  localparam int beats_tot = beats_lp + 1;
`else
  localparam int beats_tot = beats_lp;
`endif
  localparam int cnt_w = (beats_tot > 1) ? $clog2(beats_tot) : 1;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(beats_tot - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_n;
  logic [width_p-1:0] shift_r;
  logic [width_p-1:0] hold_r;
  logic               hold_v_r;
  logic [cnt_w-1:0]   count_r;

  logic               running;
  logic               accept;
  logic               xfer;
  logic               last_beat;
  logic               load_in;
  logic               load_hold;
  logic               shift_en;
  logic               clear_sh;
  logic               hold_wr;
  logic [lanes_p-1:0] head;
  logic [width_p-1:0] shifted;
  logic [lanes_p-1:0] beat_dat;

  // Outputs are forced quiet while reset is held so nothing transfers mid-reset.
  assign ready_o   = ~hold_v_r & ~reset_i;
  assign running   = (state_r == SHIFT) & ~reset_i;
  assign accept    = v_i & ready_o;
  assign xfer      = running & ready_i;
  assign last_beat = (count_r == last_cnt);

  // The outgoing beat always sits at the "head" end of the shifter; the shift
  // direction decides which end that is.
  generate
    if (lsb_first_p != 0) begin : g_lsb
      assign head    = shift_r[lanes_p-1:0];
      assign shifted = shift_r >> lanes_p;
    end else begin : g_msb
      assign head    = shift_r[width_p-1 -: lanes_p];
      assign shifted = shift_r << lanes_p;
    end
  endgenerate

`ifdef MP_SERIALIZER_PARITY_EN
  // Parity accumulates from the beats actually transferred, so it needs no
  // separate fold of the word at load time (hold or direct path alike).
  logic [lanes_p-1:0] par_r;

  assign beat_dat = last_beat ? par_r : head;

  always_ff @(posedge clk_i) begin
    if (reset_i || load_in || load_hold || clear_sh) begin
      par_r <= '0;
    end else if (xfer && !last_beat) begin
      par_r <= par_r ^ head;
    end
  end
`else
  assign beat_dat = head;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_n   = state_r;
    load_in   = 1'b0;
    load_hold = 1'b0;
    shift_en  = 1'b0;
    clear_sh  = 1'b0;
    hold_wr   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept) begin
          load_in = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer && last_beat) begin
          // Refill immediately so the next word follows with no bubble;
          // the held word has priority because it was accepted earlier.
          if (hold_v_r) begin
            load_hold = 1'b1;
          end else if (accept) begin
            load_in = 1'b1;
          end else begin
            clear_sh = 1'b1;
            state_n  = IDLE;
          end
        end else if (xfer) begin
          shift_en = 1'b1;
        end
        // An accepted word that is not going straight into the shifter parks
        // in the holding register. ready_o is low while it is full, so this
        // never overwrites a pending word.
        if (accept && !load_in) begin
          hold_wr = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= IDLE;
      shift_r  <= '0;
      count_r  <= '0;
      hold_r   <= '0;
      hold_v_r <= 1'b0;
    end else begin
      state_r <= state_n;

      if (load_in) begin
        shift_r <= data_i;
        count_r <= '0;
      end else if (load_hold) begin
        shift_r <= hold_r;
        count_r <= '0;
      end else if (clear_sh) begin
        shift_r <= '0;
        count_r <= '0;
      end else if (shift_en) begin
        shift_r <= shifted;
        count_r <= count_r + cnt_w'(1);
      end

      if (hold_wr) begin
        hold_r   <= data_i;
        hold_v_r <= 1'b1;
      end else if (load_hold) begin
        hold_v_r <= 1'b0;
      end
    end
  end

  assign v_o    = running;
  assign data_o = running ? beat_dat : '0;
  assign sof_o  = running & (count_r == '0);
  assign eof_o  = running & last_beat;

endmodule
